// File: rtl/des_nic_input_block.sv
// -----------------------------------------------------------------------------
// des_nic_input_block
//   Input stage of the DES network interface. Assembles 5-flit request packets
//   (header, pt_low, pt_high, key_low, key_high) from the router, launches the
//   DES processing element when the output side has credits, presents the
//   hop-shifted header to the output stage and returns flit credits upstream.
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous active-low reset
//   input_channel_din   : flit from router (all-zero when idle)
//   credit_out_dout     : one pulse per returned flit credit
//   zero_credits_din    : output stage has no downstream credits
//   done_strobe_din     : PE finished (one-cycle pulse)
//   start_strobe_dout   : PE launch pulse (one cycle)
//   plaintext_dout      : {pt_high, pt_low}, valid in the start cycle only
//   key_dout            : {key_high, key_low}, valid in the start cycle only
//   shifted_header_dout : header with routing bits consumed, for output stage
// -----------------------------------------------------------------------------
module des_nic_input_block #(
  parameter int unsigned CHANNEL_WIDTH = 32,
  parameter int unsigned HOP_BITS      = 4,
  parameter int unsigned PACKET_FLITS  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNEL_WIDTH-1:0]     input_channel_din,
  output logic                         credit_out_dout,
  input  logic                         zero_credits_din,
  input  logic                         done_strobe_din,
  output logic                         start_strobe_dout,
  output logic [2*CHANNEL_WIDTH-1:0]   plaintext_dout,
  output logic [2*CHANNEL_WIDTH-1:0]   key_dout,
  output logic [CHANNEL_WIDTH-1:0]     shifted_header_dout
);

  localparam int unsigned CW    = CHANNEL_WIDTH;
  localparam int unsigned CNT_W = $clog2(PACKET_FLITS + 1);

  // Buffer slot assignment within a packet
  localparam int unsigned SLOT_HDR    = 0;
  localparam int unsigned SLOT_PT_LO  = 1;
  localparam int unsigned SLOT_PT_HI  = 2;
  localparam int unsigned SLOT_KEY_LO = 3;
  localparam int unsigned SLOT_KEY_HI = 4;

  typedef enum logic [1:0] {
    RX_EMPTY = 2'd0,
    RX_RECV  = 2'd1,
    RX_FULL  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_BUSY  = 2'd1,
    ISS_DRAIN = 2'd2
  } issue_state_e;

  rx_state_e        rx_q, rx_d;
  issue_state_e     issue_q, issue_d;
  logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CW-1:0]    buf_q [PACKET_FLITS];
  logic [CW-1:0]    buf_d [PACKET_FLITS];
  logic [CW-1:0]    shdr_q, shdr_d;
  logic             start_c;
  logic             is_header_c;
  logic             unused_hdr_bits;

  // Routing bits shifted out of the header are intentionally dropped
  assign unused_hdr_bits = ^buf_q[SLOT_HDR][CW-1:CW-1-HOP_BITS];

  assign is_header_c = input_channel_din[CW-1];

  // Launch when a full packet is waiting, the PE is free and output has credits
  assign start_c = (rx_q == RX_FULL) && (issue_q == ISS_IDLE) && !zero_credits_din;

  // Next-state logic for receive FSM, issue FSM and credit return
  always_comb begin
    rx_d         = rx_q;
    issue_d      = issue_q;
    flit_cnt_d   = flit_cnt_q;
    credit_cnt_d = credit_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    buf_d        = buf_q;
    shdr_d       = shdr_q;

    // Receive side
    case (rx_q)
      RX_EMPTY: begin
        if (is_header_c) begin
          buf_d[SLOT_HDR] = input_channel_din;
          flit_cnt_d      = CNT_W'(1);
          rx_d            = RX_RECV;
        end
      end
      RX_RECV: begin
        for (int i = 1; i < int'(PACKET_FLITS); i++) begin
          if (flit_cnt_q == CNT_W'(i)) begin
            buf_d[i] = input_channel_din;
          end
        end
        flit_cnt_d = flit_cnt_q + CNT_W'(1);
        if (flit_cnt_q == CNT_W'(PACKET_FLITS - 1)) begin
          rx_d = RX_FULL;
        end
      end
      RX_FULL: begin
        // Buffer frees in the start cycle; a header arriving alongside is kept
        if (start_c) begin
          rx_d       = RX_EMPTY;
          flit_cnt_d = '0;
          if (is_header_c) begin
            buf_d[SLOT_HDR] = input_channel_din;
            flit_cnt_d      = CNT_W'(1);
            rx_d            = RX_RECV;
          end
        end
      end
      default: begin
        rx_d       = RX_EMPTY;
        flit_cnt_d = '0;
      end
    endcase

    // Credit return: one pulse per cycle while the counter is nonzero
    if (credit_cnt_q != '0) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end

    // Issue side
    case (issue_q)
      ISS_IDLE: begin
        if (start_c) begin
          issue_d      = ISS_BUSY;
          credit_cnt_d = CNT_W'(PACKET_FLITS);
          shdr_d       = {1'b1, buf_q[SLOT_HDR][CW-2-HOP_BITS:0], {HOP_BITS{1'b0}}};
        end
      end
      ISS_BUSY: begin
        // The done cycle counts as the first drain cycle, so the next start
        // can land PACKET_FLITS cycles after done
        if (done_strobe_din) begin
          issue_d     = ISS_DRAIN;
          drain_cnt_d = CNT_W'(PACKET_FLITS - 1);
        end
      end
      ISS_DRAIN: begin
        if (drain_cnt_q <= CNT_W'(1)) begin
          drain_cnt_d = '0;
          issue_d     = ISS_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        issue_d     = ISS_IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q         <= RX_EMPTY;
      issue_q      <= ISS_IDLE;
      flit_cnt_q   <= '0;
      credit_cnt_q <= '0;
      drain_cnt_q  <= '0;
      buf_q        <= '{default: '0};
      shdr_q       <= '0;
    end else begin
      rx_q         <= rx_d;
      issue_q      <= issue_d;
      flit_cnt_q   <= flit_cnt_d;
      credit_cnt_q <= credit_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      buf_q        <= buf_d;
      shdr_q       <= shdr_d;
    end
  end

  // Outputs: operands are only driven during the launch cycle
  assign start_strobe_dout   = start_c;
  assign credit_out_dout     = (credit_cnt_q != '0);
  assign shifted_header_dout = shdr_q;
  assign plaintext_dout      = start_c ? {buf_q[SLOT_PT_HI], buf_q[SLOT_PT_LO]}
                                       : '0;
  assign key_dout            = start_c ? {buf_q[SLOT_KEY_HI], buf_q[SLOT_KEY_LO]}
                                       : '0;

endmodule

// File: tb/tb_des_nic_input_block.sv
// -----------------------------------------------------------------------------
// tb_des_nic_input_block
//   Directed self-checking bench for des_nic_input_block: reset, reset during
//   receive, noise rejection, single packet launch, back-to-back packets with
//   PE drain timing, and zero-credit stalling.
// -----------------------------------------------------------------------------
module tb_des_nic_input_block;

  localparam int unsigned CW = 32;

  logic          clk;
  logic          reset;
  logic [CW-1:0] din;
  logic          credit_out;
  logic          zero_credits;
  logic          done_strobe;
  logic          start_strobe;
  logic [63:0]   plaintext;
  logic [63:0]   key;
  logic [CW-1:0] shdr;

  int errors;
  int checks;

  des_nic_input_block #(
    .CHANNEL_WIDTH(32),
    .HOP_BITS     (4),
    .PACKET_FLITS (5)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .input_channel_din  (din),
    .credit_out_dout    (credit_out),
    .zero_credits_din   (zero_credits),
    .done_strobe_din    (done_strobe),
    .start_strobe_dout  (start_strobe),
    .plaintext_dout     (plaintext),
    .key_dout           (key),
    .shifted_header_dout(shdr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [CW-1:0] h, input logic [CW-1:0] p0,
                             input logic [CW-1:0] p1, input logic [CW-1:0] k0,
                             input logic [CW-1:0] k1);
    logic [CW-1:0] flits [5];
    flits = '{h, p0, p1, k0, k1};
    for (int i = 0; i < 5; i++) begin
      din = flits[i];
      @(negedge clk);
      checks++;
      if (start_strobe !== 1'b0) begin
        errors++;
        $display("FAIL rx_no_start flit%0d: got %b want 0", i, start_strobe);
      end
      cyc();
    end
    din = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din = '0;
    zero_credits = 1'b0;
    done_strobe = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if ({start_strobe, credit_out} !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00", {start_strobe, credit_out});
    end
    checks++;
    if (plaintext !== 64'h0 || key !== 64'h0) begin
      errors++;
      $display("FAIL reset_operands: got pt=%h key=%h want 0", plaintext, key);
    end
    checks++;
    if (shdr !== 32'h0) begin
      errors++;
      $display("FAIL reset_shdr: got %h want 0", shdr);
    end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_recv();
    din = 32'h8000_0001;
    cyc();
    din = 32'hDEAD_BEEF;
    cyc();
    din = 32'hCAFE_F00D;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({start_strobe, credit_out, shdr, plaintext, key} !== '0) begin
      errors++;
      $display("FAIL midrecv_reset_outputs: got start=%b credit=%b shdr=%h want all 0",
               start_strobe, credit_out, shdr);
    end
    cyc();
    reset = 1'b1;
    din = '0;
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b0) begin
      errors++;
      $display("FAIL midrecv_after_release: got start=%b want 0", start_strobe);
    end
    cyc();
  endtask

  task automatic test_noise_and_idle_done();
    din = 32'h0000_1234;
    done_strobe = 1'b1;
    cyc();
    din = '0;
    done_strobe = 1'b0;
    @(negedge clk);
    checks++;
    if ({start_strobe, credit_out} !== 2'b00) begin
      errors++;
      $display("FAIL noise_strobes: got %b want 00", {start_strobe, credit_out});
    end
    checks++;
    if (shdr !== 32'h0) begin
      errors++;
      $display("FAIL noise_shdr: got %h want 0", shdr);
    end
    cyc();
  endtask

  task automatic test_single_packet();
    send_packet(32'h8000_00A5, 32'h0123_4567, 32'h89AB_CDEF,
                32'h1334_5779, 32'h9BBC_DFF1);
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b1) begin
      errors++;
      $display("FAIL single_start: got %b want 1", start_strobe);
    end
    checks++;
    if (plaintext !== 64'h89AB_CDEF_0123_4567) begin
      errors++;
      $display("FAIL single_pt: got %h want 89abcdef01234567", plaintext);
    end
    checks++;
    if (key !== 64'h9BBC_DFF1_1334_5779) begin
      errors++;
      $display("FAIL single_key: got %h want 9bbcdff113345779", key);
    end
    checks++;
    if (credit_out !== 1'b0) begin
      errors++;
      $display("FAIL single_no_early_credit: got %b want 0", credit_out);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (credit_out !== 1'b1 || start_strobe !== 1'b0) begin
        errors++;
        $display("FAIL single_credit%0d: got credit=%b start=%b want 1 0",
                 i, credit_out, start_strobe);
      end
      checks++;
      if (shdr !== 32'h8000_0A50 || plaintext !== 64'h0) begin
        errors++;
        $display("FAIL single_shdr%0d: got shdr=%h pt=%h want 80000a50 0",
                 i, shdr, plaintext);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (credit_out !== 1'b0) begin
      errors++;
      $display("FAIL single_credit_end: got %b want 0", credit_out);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    send_packet(32'h8000_0123, 32'h1111_1111, 32'h2222_2222,
                32'h3333_3333, 32'h4444_4444);
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_hold: got start=%b want 0", start_strobe);
    end
    cyc();
    done_strobe = 1'b1;
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle: got start=%b want 0", start_strobe);
    end
    cyc();
    done_strobe = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (start_strobe !== 1'b0 || shdr !== 32'h8000_0A50) begin
        errors++;
        $display("FAIL b2b_drain%0d: got start=%b shdr=%h want 0 80000a50",
                 i, start_strobe, shdr);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b1 || shdr !== 32'h8000_0A50) begin
      errors++;
      $display("FAIL b2b_start: got start=%b shdr=%h want 1 80000a50",
               start_strobe, shdr);
    end
    checks++;
    if (plaintext !== 64'h2222_2222_1111_1111 || key !== 64'h4444_4444_3333_3333) begin
      errors++;
      $display("FAIL b2b_operands: got pt=%h key=%h want 2222222211111111 4444444433333333",
               plaintext, key);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (shdr !== 32'h8000_1230 || credit_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_shdr: got shdr=%h credit=%b want 80001230 1", shdr, credit_out);
    end
    for (int i = 0; i < 5; i++) cyc();
    // Release the PE and let the drain finish so issue is idle again
    done_strobe = 1'b1;
    cyc();
    done_strobe = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
  endtask

  task automatic test_zero_credits();
    zero_credits = 1'b1;
    send_packet(32'h8765_4321, 32'hAAAA_AAAA, 32'h5555_5555,
                32'h0F0F_0F0F, 32'hF0F0_F0F0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (start_strobe !== 1'b0 || credit_out !== 1'b0) begin
        errors++;
        $display("FAIL zc_stall%0d: got start=%b credit=%b want 0 0",
                 i, start_strobe, credit_out);
      end
      cyc();
    end
    zero_credits = 1'b0;
    @(negedge clk);
    checks++;
    if (start_strobe !== 1'b1) begin
      errors++;
      $display("FAIL zc_release_start: got %b want 1", start_strobe);
    end
    checks++;
    if (plaintext !== 64'h5555_5555_AAAA_AAAA || key !== 64'hF0F0_F0F0_0F0F_0F0F) begin
      errors++;
      $display("FAIL zc_operands: got pt=%h key=%h want 55555555aaaaaaaa f0f0f0f00f0f0f0f",
               plaintext, key);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (credit_out !== 1'b1 || shdr !== 32'hF654_3210) begin
        errors++;
        $display("FAIL zc_credit%0d: got credit=%b shdr=%h want 1 f6543210",
                 i, credit_out, shdr);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (credit_out !== 1'b0) begin
      errors++;
      $display("FAIL zc_credit_end: got %b want 0", credit_out);
    end
    cyc();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    din = '0;
    zero_credits = 1'b0;
    done_strobe = 1'b0;
    test_reset();
    test_reset_mid_recv();
    test_noise_and_idle_done();
    test_single_packet();
    test_back_to_back();
    test_zero_credits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
